// File: rtl/core_fpu_ctrl.sv
// core_fpu_ctrl
// Sequencer between the core datapath and an external FPU that uses
// AXI4-Stream style operand (A, B), opcode (OP) and result (R) channels.
// One request is issued at a time: the opcode and both operands go out on
// their channels, and each channel's valid/ready handshake completes on its
// own. The result is then collected on R and returned to the core with a
// one-cycle DONE strobe. An optional timeout aborts the wait for the result
// and flags ERR.
//
// Parameters
//   TIMEOUT  maximum number of cycles spent waiting for R before abort (0 = never)
//   CNT_W    width of the timeout counter (TIMEOUT < 2**CNT_W)
//
// Ports
//   CLK, RST_N                    clock, asynchronous active-low reset
//   REQ, REQ_OP, REQ_A, REQ_B     core request (sampled only while idle)
//   BUSY, DONE, ERR, RESULT       core status / result (all registered)
//   A_*, B_*, OP_*                outbound operand and opcode streams
//   R_*                           inbound result stream
module core_fpu_ctrl #(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic [7:0]  REQ_OP,
    input  logic [31:0] REQ_A,
    input  logic [31:0] REQ_B,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RESULT,
    output logic [31:0] A_TDATA,
    output logic        A_TVALID,
    input  logic        A_TREADY,
    output logic [31:0] B_TDATA,
    output logic        B_TVALID,
    input  logic        B_TREADY,
    output logic [7:0]  OP_TDATA,
    output logic        OP_TVALID,
    input  logic        OP_TREADY,
    input  logic [31:0] R_TDATA,
    input  logic        R_TVALID,
    output logic        R_TREADY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Last counter value before the abort fires; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] LIMIT   = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic              a_sent, b_sent, op_sent;
    logic              a_sent_nxt, b_sent_nxt, op_sent_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              busy_nxt, done_nxt, err_nxt, r_rdy_nxt;
    logic [31:0]       result_nxt, a_data_nxt, b_data_nxt;
    logic [7:0]        op_data_nxt;
    logic              a_vld_nxt, b_vld_nxt, op_vld_nxt;
    logic              a_hs, b_hs, op_hs;

    assign a_hs  = A_TVALID  & A_TREADY;
    assign b_hs  = B_TVALID  & B_TREADY;
    assign op_hs = OP_TVALID & OP_TREADY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            a_sent    <= 1'b0;
            b_sent    <= 1'b0;
            op_sent   <= 1'b0;
            cnt       <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            RESULT    <= '0;
            A_TDATA   <= '0;
            A_TVALID  <= 1'b0;
            B_TDATA   <= '0;
            B_TVALID  <= 1'b0;
            OP_TDATA  <= '0;
            OP_TVALID <= 1'b0;
            R_TREADY  <= 1'b0;
        end else begin
            state     <= state_nxt;
            a_sent    <= a_sent_nxt;
            b_sent    <= b_sent_nxt;
            op_sent   <= op_sent_nxt;
            cnt       <= cnt_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
            ERR       <= err_nxt;
            RESULT    <= result_nxt;
            A_TDATA   <= a_data_nxt;
            A_TVALID  <= a_vld_nxt;
            B_TDATA   <= b_data_nxt;
            B_TVALID  <= b_vld_nxt;
            OP_TDATA  <= op_data_nxt;
            OP_TVALID <= op_vld_nxt;
            R_TREADY  <= r_rdy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        a_sent_nxt  = a_sent;
        b_sent_nxt  = b_sent;
        op_sent_nxt = op_sent;
        cnt_nxt     = cnt;
        busy_nxt    = BUSY;
        done_nxt    = DONE;
        err_nxt     = ERR;
        result_nxt  = RESULT;
        a_data_nxt  = A_TDATA;
        a_vld_nxt   = A_TVALID;
        b_data_nxt  = B_TDATA;
        b_vld_nxt   = B_TVALID;
        op_data_nxt = OP_TDATA;
        op_vld_nxt  = OP_TVALID;
        r_rdy_nxt   = R_TREADY;

        case (state)
            S_IDLE: begin
                if (REQ) begin
                    state_nxt   = S_ISSUE;
                    a_data_nxt  = REQ_A;
                    b_data_nxt  = REQ_B;
                    op_data_nxt = REQ_OP;
                    a_vld_nxt   = 1'b1;
                    b_vld_nxt   = 1'b1;
                    op_vld_nxt  = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end

            S_ISSUE: begin
                if (a_hs) begin
                    a_vld_nxt  = 1'b0;
                    a_sent_nxt = 1'b1;
                end
                if (b_hs) begin
                    b_vld_nxt  = 1'b0;
                    b_sent_nxt = 1'b1;
                end
                if (op_hs) begin
                    op_vld_nxt  = 1'b0;
                    op_sent_nxt = 1'b1;
                end
                // Move on once every channel is either already sent or
                // completing right now.
                if ((a_sent | a_hs) && (b_sent | b_hs) && (op_sent | op_hs)) begin
                    state_nxt = S_WAIT;
                    r_rdy_nxt = 1'b1;
                end
            end

            S_WAIT: begin
                // A result on the limit cycle takes priority over the abort.
                if (R_TVALID) begin
                    result_nxt = R_TDATA;
                    r_rdy_nxt  = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = S_DONE;
                end else if (TIMEOUT != 0) begin
                    if (cnt == LIMIT) begin
                        result_nxt = '0;
                        r_rdy_nxt  = 1'b0;
                        done_nxt   = 1'b1;
                        err_nxt    = 1'b1;
                        state_nxt  = S_DONE;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            S_DONE: begin
                done_nxt    = 1'b0;
                err_nxt     = 1'b0;
                busy_nxt    = 1'b0;
                a_sent_nxt  = 1'b0;
                b_sent_nxt  = 1'b0;
                op_sent_nxt = 1'b0;
                cnt_nxt     = '0;
                state_nxt   = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
